vga_ddp: RTL
============

VGA_DDP -- requirements
Module: vga_ddp

Interface
REQ-001 Parameter H_ACTIVE, default 800, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 600, active lines per frame.
REQ-003 Parameter FB_W, default 200, frame-buffer width (H_ACTIVE/4).
REQ-004 Parameter FB_H, default 150, frame-buffer height (V_ACTIVE/4).
REQ-005 Port list (name, direction, width, meaning); clock and reset first:
- clk_px, input, 1, pixel clock, 50 MHz.
- rst, input, 1, asynchronous reset, active-high.
- hen, input, 1, horizontal display enable from scan timing.
- ven, input, 1, vertical display enable from scan timing.
- hs, input, 1, line sync from scan timing.
- vs, input, 1, frame sync from scan timing.
- raddr, output, 15, frame-buffer read address.
- rdata, input, 12, frame-buffer read data, RGB444; synchronous RAM with 1-cycle latency.
- test_en, input, 1, test-pattern select; only present under macro, see REQ-022.
- rgb, output, 12, pixel colour to DAC.
- de_o, output, 1, delayed display enable.
- hs_o, output, 1, delayed hs.
- vs_o, output, 1, delayed vs.
- frame_done, output, 1, one-cycle pulse after last active pixel of frame.

Function
REQ-006 de = hen & ven; a cycle with de=1 is one active pixel.
REQ-007 Each frame-buffer pixel covers a 4x4 screen block: sub-column counter sx (2 bits), sub-row counter sy (2 bits).
REQ-008 Internal registers: addr (15 b) and line base (15 b); raddr = addr, combinational from the register, no added delay.
REQ-009 On a de=1 cycle: sx <= sx+1 (mod 4); addr <= addr+1 when sx==3.
REQ-010 On a de falling edge (de_d=1, de=0), end of line:
- sx <= 0 and sy <= sy+1 (mod 4).
- If sy==3: base <= base+FB_W and addr <= base+FB_W.
- Otherwise: addr <= base.
REQ-011 While ven=0, sx, sy, addr and base are held at 0.
REQ-012 No multiplier is used; address generation is incremental only.
REQ-013 Pipeline latency is 2 cycles: pixel presented at cycle t produces rgb at t+2.
REQ-014 de_o, hs_o and vs_o equal de, hs and vs delayed exactly 2 cycles.
REQ-015 rgb = rdata (registered) when the 1-cycle-delayed de is 1; otherwise rgb = 12'h000 (blanking).
REQ-016 frame_done pulses for 1 cycle, aligned with de_o, on the de_o falling edge of the last active line (line V_ACTIVE-1), once per frame.
REQ-017 Addressing ranges:
- Last active pixel of the frame addresses FB_W*FB_H-1 = 29999.
- addr never exceeds 29999 within a frame.
- addr resets to 0 when ven falls.
REQ-018 A frame with fewer than V_ACTIVE lines (ven drops early) produces no frame_done; the next frame restarts at addr 0.
REQ-019 A line with fewer than H_ACTIVE pixels uses the same end-of-line rule; no error is flagged.

Reset
REQ-020 On rst=1, asynchronously:
- rgb=0, de_o=0, hs_o=0, vs_o=0, frame_done=0.
- raddr=0, sx=0, sy=0, base=0, and all delay stages 0.
REQ-021 Reset released mid-frame: output stays blank until the next ven rising edge, so the first pixel emitted addresses 0.

Configuration
REQ-022 Macro VGA_DDP_TEST_PATTERN_EN:
- Defined: port test_en exists. When test_en=1, rgb during active pixels is 8 vertical colour bars of 100 pixels each: white, yellow, cyan, green, magenta, red, blue, black (F,F,F / F,F,0 / 0,F,F / 0,F,0 / F,0,F / F,0,0 / 0,0,F / 0,0,0 per nibble). rdata is ignored; latency and alignment are unchanged.
- Not defined: test_en port and bar logic are absent; rgb always follows rdata.

Verification
REQ-023 Reset asserted mid-line with rdata=12'hABC -> rgb=0, de_o=0 and raddr=0 immediately, with no clock edge required.
REQ-024 Full 800x600 frame, rdata=raddr[11:0] model -> raddr:
- Pixels 0-3 of lines 0-3 read 0.
- Pixel 4 of line 0 reads 1.
- Line 4 pixel 0 reads 200.
- Final pixel reads 29999.
- frame_done pulses once, 2 cycles after the last de.
REQ-025 Single de pulse at cycle t with rdata=12'h5A3 at t+1 -> rgb=12'h5A3 at t+2 only, 0 at t+3; hs_o/vs_o track hs/vs shifted 2 cycles.
REQ-026 ven dropped after line 300 -> no frame_done; next frame line 0 pixel 0 raddr=0.
REQ-027 With VGA_DDP_TEST_PATTERN_EN and test_en=1 -> pixel 0: rgb=FFF; pixel 150: FF0; pixel 799: 000; blanking: 000.
REQ-028 Line truncated to 10 pixels -> next line starts at base (sy<3) or base+200 (sy==3); no lockup.

Source files
------------

// File: rtl/vga_ddp.sv
// 4x-upscaling display data path: frame-buffer address generation, 2-cycle pixel pipeline.
// Optional colour-bar generator under macro VGA_DDP_TEST_PATTERN_EN (adds port test_en).
module vga_ddp #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned FB_W     = 200,
    parameter int unsigned FB_H     = 150
) (
    input  logic        clk_px,
    input  logic        rst,
    input  logic        hen,
    input  logic        ven,
    input  logic        hs,
    input  logic        vs,
    output logic [14:0] raddr,
    input  logic [11:0] rdata,
`ifdef VGA_DDP_TEST_PATTERN_EN
    input  logic        test_en,
`endif
    output logic [11:0] rgb,
    output logic        de_o,
    output logic        hs_o,
    output logic        vs_o,
    output logic        frame_done
);

    localparam int unsigned LW        = $clog2(V_ACTIVE);
    localparam logic [14:0] FB_W15    = 15'(FB_W);
    localparam logic [14:0] LAST_ADDR = 15'(FB_W * FB_H - 1);

    logic [1:0]    sx, sy;
    logic [14:0]   addr, base;
    logic [LW-1:0] lcnt;
    logic          armed;
    logic          de, de_d, eol, last_line;
    logic          hs_d, vs_d, fd_d;
    logic [14:0]   addr_inc, next_base;
    logic [11:0]   pix;

    // Armed only after ven has been seen low, so a reset released mid-frame stays blank.
    always_comb begin
        de        = hen & ven & armed;
        eol       = de_d & ~de;
        last_line = (lcnt == LW'(V_ACTIVE - 1));
        addr_inc  = (addr == LAST_ADDR) ? LAST_ADDR : addr + 15'd1;
        next_base = base + FB_W15;
    end

    assign raddr = addr;

`ifdef VGA_DDP_TEST_PATTERN_EN
    localparam int unsigned BAR_W = H_ACTIVE / 8;
    localparam int unsigned PW    = $clog2(BAR_W + 1);

    logic [PW-1:0] pcnt;
    logic [2:0]    bar_idx;
    logic [11:0]   bar_q;

    always_ff @(posedge clk_px or posedge rst) begin
        if (rst) begin
            pcnt    <= '0;
            bar_idx <= '0;
            bar_q   <= '0;
        end else begin
            // Bar colour bits: R = ~idx[1], G = ~idx[2], B = ~idx[0].
            bar_q <= {{4{~bar_idx[1]}}, {4{~bar_idx[2]}}, {4{~bar_idx[0]}}};
            if (!ven || !armed || eol) begin
                pcnt    <= '0;
                bar_idx <= '0;
            end else if (de) begin
                if (pcnt == PW'(BAR_W - 1)) begin
                    pcnt    <= '0;
                    bar_idx <= bar_idx + 3'd1;
                end else begin
                    pcnt <= pcnt + PW'(1);
                end
            end
        end
    end

    always_comb pix = test_en ? bar_q : rdata;
`else
    always_comb pix = rdata;
`endif

    always_ff @(posedge clk_px or posedge rst) begin
        if (rst) begin
            armed      <= 1'b0;
            de_d       <= 1'b0;
            de_o       <= 1'b0;
            hs_d       <= 1'b0;
            hs_o       <= 1'b0;
            vs_d       <= 1'b0;
            vs_o       <= 1'b0;
            fd_d       <= 1'b0;
            frame_done <= 1'b0;
            rgb        <= '0;
            sx         <= '0;
            sy         <= '0;
            addr       <= '0;
            base       <= '0;
            lcnt       <= '0;
        end else begin
            armed      <= armed | ~ven;
            de_d       <= de;
            de_o       <= de_d;
            hs_d       <= hs;
            hs_o       <= hs_d;
            vs_d       <= vs;
            vs_o       <= vs_d;
            fd_d       <= eol & last_line;
            frame_done <= fd_d;
            rgb        <= de_d ? pix : 12'h000;
            if (!ven || !armed) begin
                sx   <= '0;
                sy   <= '0;
                addr <= '0;
                base <= '0;
                lcnt <= '0;
            end else if (de) begin
                sx <= sx + 2'd1;
                if (sx == 2'd3) addr <= addr_inc;
            end else if (eol) begin
                sx   <= '0;
                sy   <= sy + 2'd1;
                lcnt <= lcnt + LW'(1);
                if (sy == 2'd3) begin
                    base <= next_base;
                    addr <= (next_base > LAST_ADDR) ? LAST_ADDR : next_base;
                end else begin
                    addr <= base;
                end
            end
        end
    end

endmodule
